sm_restore_serial: RTL and testbench
====================================

Name: sm_restore_serial

Overview:
- Inverse of the team's sign-magnitude subtractor, which produces |a-b| plus a negative flag (set when a<b).
- Given that magnitude/flag pair and the subtrahend b, this block reconstructs the minuend a.
- Operation: a = b + mag when neg=0; a = b - mag when neg=1.
- Bit-serial (one bit per clock, LSB first) over a valid/ready handshake, sized for the small-area ALU datapath.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..16. Elaboration error outside that range.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block idle, can accept operands
- mag  input  WIDTH  magnitude |a-b|
- neg  input  1  sign flag (1 = original a was less than b)
- b  input  WIDTH  subtrahend of original operation
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- a  output  WIDTH  reconstructed value, modulo 2^WIDTH
- ovf  output  1  neg=0: carry out of b+mag; neg=1: borrow (b<mag)

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=1 at an edge, any state): state=IDLE, in_ready=1, out_valid=0, a=0, ovf=0, bit counter=0, carry=0. Aborts any op in progress with no partial output.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture mag, neg, b into shift registers; carry<=neg; counter<=0; go to RUN.
- RUN:
  - in_ready=0; input ports ignored.
  - Each edge processes bit i: x=b_sh[0], y=mag_sh[0]^neg_q.
  - Sum bit x^y^carry shifts into result MSB; carry<=majority(x,y,carry); both operand registers shift right; counter++.
  - After WIDTH edges (counter==WIDTH-1 processed): go to DONE.
  - a<=full result; ovf<=carry^neg_q (carry for add, inverted carry for subtract).
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- DONE:
  - out_valid=1; a and ovf held stable.
  - On out_ready: go to IDLE. in_ready=1 the next cycle. No accept in the same cycle as result hand-off.
- a and ovf retain their last value in IDLE. Consumers sample them only when out_valid=1.
- Boundaries:
  - neg=1, mag=0 gives a=b, ovf=0.
  - neg=0, mag=0 gives a=b, ovf=0.
  - Wrap-around is silent modulo 2^WIDTH; ovf flags it.
  - out_ready asserted while not in DONE has no effect.
  - in_valid held through RUN/DONE is not re-accepted until IDLE.
- Round-trip property: for every a0,b0, feeding the subtractor's (|a0-b0|, a0<b0, b0) yields a=a0, ovf=0.

Decomposition:
- Shared ALU package:
  - state enum (IDLE/RUN/DONE) typedef
  - WIDTH default constant
  - counter width = clog2(WIDTH)+1
- One sub-module: reuse the team's existing one-bit FullAdder cell as the per-bit combinational stage.
- Carry, shift and counter registers stay in this module.

Test Plan:
1. WIDTH=4, neg=0, mag=3, b=5, accepted at edge E -> out_valid high after E+4, a=8, ovf=0.
2. neg=1, mag=3, b=5 -> a=2, ovf=0.
3. neg=1, mag=7, b=2 -> a=4'hB, ovf=1.
4. neg=0, mag=9, b=9 -> a=2, ovf=1.
5. out_ready held 0 for 3 cycles in DONE, with new in_valid driven -> a, ovf stable, in_ready=0, new operands ignored. out_ready=1 -> IDLE; in_ready=1 next cycle; next op correct.
6. rst=1 after 2 RUN cycles -> next cycle out_valid=0, in_ready=1, a=0, ovf=0. Then exhaustive round trip over all 256 (a0,b0) pairs through the subtractor -> a=a0, ovf=0 every time.

Source files
------------

// File: rtl/sm_restore_serial_pkg.sv
// Shared definitions for the serial sign-magnitude restore block: FSM states,
// default operand width and bit-counter sizing.
package sm_restore_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // One extra bit so the counter can always hold WIDTH-1 (WIDTH=1 still gets one bit).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/sm_restore_serial_fa.sv
// One-bit full adder cell used as the per-bit stage of the serial datapath.
module sm_restore_serial_fa (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_x ^ i_y ^ i_c;
    assign o_c = (i_x & i_y) | (i_x & i_c) | (i_y & i_c);

endmodule

// File: rtl/sm_restore_serial.sv
// Bit-serial reconstruction of a from (|a-b|, a<b, b): a = b + mag or b - mag,
// one bit per clock LSB first, with ovf reporting carry (add) or borrow (subtract).
module sm_restore_serial
    import sm_restore_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mag,
    input  logic             neg,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic             ovf,
    output state_t           dbg_state
);

    // Handshake: an operand set transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. Neither
    // ready/valid depends combinationally on the other side.

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > 16) begin : g_width_check
        $error("sm_restore_serial: WIDTH must be in 1..16");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_mag_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_neg;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_x;
    logic             w_y;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Subtraction is b + ~mag + 1: the +1 comes from seeding carry with neg.
    assign w_x    = r_b_sh[0];
    assign w_y    = r_mag_sh[0] ^ r_neg;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    sm_restore_serial_fa u_fa (
        .i_x (w_x),
        .i_y (w_y),
        .i_c (r_carry),
        .o_s (w_sum),
        .o_c (w_cout)
    );

    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_b_sh      <= '0;
            r_mag_sh    <= '0;
            r_res       <= '0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_b_sh     <= b;
                        r_mag_sh   <= mag;
                        r_neg      <= neg;
                        r_carry    <= neg;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res    <= w_res_next;
                    r_carry  <= w_cout;
                    r_b_sh   <= r_b_sh >> 1;
                    r_mag_sh <= r_mag_sh >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_a         <= w_res_next;
                        r_ovf       <= w_cout ^ r_neg;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sm_restore_serial.sv
// Self-checking bench for sm_restore_serial: directed cases, handshake/abort
// checks, exhaustive round trip and randomized ops against an arithmetic model.
module tb_sm_restore_serial;
    import sm_restore_serial_pkg::*;

    localparam int W   = 4;
    localparam int LIM = 40;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] mag;
    logic         neg;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic         ovf;
    state_t       dbg_state;

    int checks;
    int errors;

    // Expected results as {ovf, a}.
    logic [W:0] exp_q[$];

    sm_restore_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag       (mag),
        .neg       (neg),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the restored value.
    function automatic logic [W:0] model(input int m, input int n, input int bb);
        int r;
        logic o;
        if (n != 0) begin
            r = bb - m;
            o = (bb < m);
        end else begin
            r = bb + m;
            o = (r >= (1 << W));
        end
        return {o, W'(r & ((1 << W) - 1))};
    endfunction

    // Present one operand set, wait for the result, check latency and value.
    // hold_cycles > 0 keeps out_ready low in DONE while junk operands are offered.
    task automatic do_op(input logic [W-1:0] m, input logic n, input logic [W-1:0] bb,
                         input logic [W:0] exp, input bit early_ready, input int hold_cycles);
        int lat;
        logic [W:0] e;
        exp_q.push_back(exp);
        check("in_ready_before", in_ready, 1);
        mag = m; neg = n; b = bb; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        mag = W'($urandom); neg = 1'($urandom); b = W'($urandom);
        lat = 0;
        while (lat < LIM) begin
            out_ready = early_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        e = exp_q.pop_front();
        if (!out_valid) begin
            check("timeout", lat, W);
            out_ready = 1'b0;
            return;
        end
        check("latency", lat, W);
        check("result_a", a, e[W-1:0]);
        check("result_ovf", ovf, e[W]);
        check("in_ready_run", in_ready, 0);
        out_ready = 1'b0;
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid = 1'b1; mag = W'($urandom); neg = 1'($urandom); b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_a", a, e[W-1:0]);
            check("hold_ovf", ovf, e[W]);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_a_held", a, e[W-1:0]);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mag = '0; neg = 1'b0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_a", a, 0);
        check("rst_ovf", ovf, 0);

        // Directed cases with constant expectations.
        do_op(4'd3, 1'b0, 4'd5, {1'b0, 4'd8},  1'b0, 0);
        do_op(4'd3, 1'b1, 4'd5, {1'b0, 4'd2},  1'b0, 0);
        do_op(4'd7, 1'b1, 4'd2, {1'b1, 4'hB},  1'b1, 0);
        do_op(4'd9, 1'b0, 4'd9, {1'b1, 4'd2},  1'b0, 0);
        do_op(4'd0, 1'b1, 4'd6, {1'b0, 4'd6},  1'b0, 0);
        do_op(4'd0, 1'b0, 4'd6, {1'b0, 4'd6},  1'b0, 0);
        do_op(4'd4, 1'b1, 4'd9, {1'b0, 4'd5},  1'b0, 3);
        do_op(4'd1, 1'b0, 4'd1, {1'b0, 4'd2},  1'b0, 0);

        // Abort mid-run: no result, outputs cleared.
        mag = 4'd5; neg = 1'b0; b = 4'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_a", a, 0);
        check("abort_ovf", ovf, 0);
        repeat (W + 1) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end

        // Round trip through the subtractor's view of every (a0, b0).
        for (int a0 = 0; a0 < (1 << W); a0++) begin
            for (int b0 = 0; b0 < (1 << W); b0++) begin
                do_op(W'((a0 >= b0) ? a0 - b0 : b0 - a0), (a0 < b0), W'(b0),
                      {1'b0, W'(a0)}, 1'($urandom_range(0, 1)), 0);
            end
        end

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] rm;
            logic [W-1:0] rb;
            logic         rn;
            rm = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rn = 1'($urandom_range(0, 1));
            do_op(rm, rn, rb, model(rm, rn, rb), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
